// File: rtl/serial_rotator_pkg.sv
// rtl/serial_rotator_pkg.sv - shared types and shortest-path planning for the serial rotator
package serial_rotator_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      ROT_LEFT  = 1'b0,
      ROT_RIGHT = 1'b1
   } rot_dir_t;

   typedef struct packed {
      rot_dir_t    dir;
      int unsigned steps;
   } rot_plan_t;

   // Fold the request into an equivalent left amount, then take the shorter way round; ties go left.
   function automatic rot_plan_t plan_rotation(input int unsigned amount, input logic dir,
                                               input int unsigned n);
      int unsigned s;
      int unsigned l;
      rot_plan_t   p;
      s = amount % n;
      l = dir ? ((n - s) % n) : s;
      if (l <= n - l) begin
         p.dir   = ROT_LEFT;
         p.steps = l;
      end else begin
         p.dir   = ROT_RIGHT;
         p.steps = n - l;
      end
      return p;
   endfunction

endpackage

// File: rtl/rotate_by_one_bit.sv
// rtl/rotate_by_one_bit.sv - combinational single-position circular rotate
module rotate_by_one_bit
   import serial_rotator_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] data,
   input  rot_dir_t     dir,
   output logic [N-1:0] rotated
);

   always_comb begin
      if (dir == ROT_RIGHT) rotated = {data[0], data[N-1:1]};
      else                  rotated = {data[N-2:0], data[N-1]};
   end

endmodule

// File: rtl/serial_circular_rotator.sv
// rtl/serial_circular_rotator.sv - multi-cycle variable-amount circular rotator, one bit per cycle
module serial_circular_rotator
   import serial_rotator_pkg::*;
#(
   parameter int N  = 8,
   parameter int SW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_data,
   input  logic [SW-1:0] in_amount,
   input  logic          in_dir,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  out_data
);

   localparam int CW = $clog2(N / 2 + 1);

   state_t        state_q, state_d;
   logic [N-1:0]  work_q, work_d;
   logic [CW-1:0] cnt_q, cnt_d;
   rot_dir_t      dir_q, dir_d;
   logic          in_ready_q, in_ready_d;
   logic          out_valid_q, out_valid_d;

   rot_plan_t     plan;
   logic [CW-1:0] plan_steps;
   logic [N-1:0]  rot_one;

   rotate_by_one_bit #(.N(N)) u_rot (
      .data    (work_q),
      .dir     (dir_q),
      .rotated (rot_one)
   );

   always_comb begin
      plan       = plan_rotation(32'(in_amount), in_dir, N);
      plan_steps = CW'(plan.steps);
   end

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               work_d     = in_data;
               cnt_d      = plan_steps;
               dir_d      = plan.dir;
               in_ready_d = 1'b0;
               if (plan_steps == '0) begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            work_d = rot_one;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
            end
         end
         DONE: begin
            // in_ready only returns the cycle after the handshake, so no same-cycle re-accept.
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         work_q      <= '0;
         cnt_q       <= '0;
         dir_q       <= ROT_LEFT;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = work_q;

endmodule

// File: tb/tb_serial_circular_rotator.sv
// tb/tb_serial_circular_rotator.sv - directed self-checking bench for serial_circular_rotator
module tb_serial_circular_rotator;

   localparam int N  = 8;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_data;
   logic [SW-1:0] in_amount;
   logic          in_dir;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  out_data;

   int n_cmp = 0;
   int n_bad = 0;

   serial_circular_rotator #(.N(N), .SW(SW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amount (in_amount),
      .in_dir    (in_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request, wait for the accept edge, and return with in_valid dropped.
   task automatic issue(input logic [N-1:0] d, input logic [SW-1:0] amt, input logic dir,
                        input string tag);
      int guard;
      guard = 0;
      while (!in_ready && guard < 50) begin
         tick();
         guard++;
      end
      check({tag, "_ready_to"}, 32'(in_ready), 32'd1);
      in_valid  = 1'b1;
      in_data   = d;
      in_amount = amt;
      in_dir    = dir;
      tick();
      in_valid  = 1'b0;
      in_data   = 8'h5a;
      check({tag, "_inrdy_low"}, 32'(in_ready), 32'd0);
   endtask

   task automatic run_req(input logic [N-1:0] d, input logic [SW-1:0] amt, input logic dir,
                          input logic [N-1:0] exp_data, input int exp_lat, input int hold,
                          input string tag);
      int lat;
      logic [N-1:0] held;
      out_ready = 1'b0;
      issue(d, amt, dir, tag);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_data"}, 32'(out_data), 32'(exp_data));
      held = out_data;
      for (int i = 0; i < hold; i++) begin
         tick();
         check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, "_hold_data"}, 32'(out_data), 32'(held));
         check({tag, "_hold_inrdy"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_post_inrdy"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amount = '0;
      in_dir    = 1'b0;
      out_ready = 1'b0;
      #2;
      check("rst_inrdy", 32'(in_ready), 32'd1);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(out_data), 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();

      run_req(8'b10110101, 3'd3, 1'b0, 8'b10101101, 3, 0, "l3");
      run_req(8'b10110101, 3'd3, 1'b1, 8'b10110110, 3, 0, "r3");
      run_req(8'b00000001, 3'd6, 1'b0, 8'b01000000, 2, 0, "l6");
      run_req(8'b00000001, 3'd4, 1'b0, 8'b00010000, 4, 0, "l4tie");
      run_req(8'b10110101, 3'd7, 1'b1, 8'b01101011, 1, 0, "r7");
      run_req(8'b10110101, 3'd5, 1'b1, 8'b10101101, 3, 0, "r5");
      run_req(8'b11100000, 3'd0, 1'b0, 8'b11100000, 0, 2, "a0");
      run_req(8'b11000011, 3'd2, 1'b1, 8'b11110000, 2, 5, "bp");
      run_req(8'b10000000, 3'd1, 1'b0, 8'b00000001, 1, 0, "b2b");

      // Reset mid-rotation must clear outputs without a clock edge.
      out_ready = 1'b0;
      issue(8'b10110101, 3'd3, 1'b0, "mid");
      tick();
      check("mid_busy_valid", 32'(out_valid), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_inrdy", 32'(in_ready), 32'd1);
      check("mid_rst_data", 32'(out_data), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      run_req(8'b10110101, 3'd3, 1'b0, 8'b10101101, 3, 0, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_circular_rotator.md
Name: serial_circular_rotator

Overview:
- Multi-cycle, variable-amount circular rotator for N-bit words, with valid/ready handshakes on both input and output.
- Complements the fixed-amount combinational left/right circular shifters. Amount and direction are runtime inputs.
- The word is rotated one bit per cycle, always along the shorter path around the ring.
- Used where area matters more than latency, e.g. the rotation stage of a serial datapath.

Parameters:
- N, 8, word width in bits; N >= 2.
- SW, $clog2(N), width of the amount input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- in_data  input  N  word to rotate.
- in_amount  input  SW  rotate amount, taken modulo N.
- in_dir  input  1  0 = rotate left (toward MSB, MSB wraps to LSB); 1 = rotate right.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  rotated word.

Behaviour:
- Reset (async, active-high): state = IDLE, in_ready = 1, out_valid = 0, out_data = 0, step counter = 0. Takes effect immediately, including mid-rotation; any in-flight request is discarded.
- Normalisation at accept:
  - S = in_amount mod N.
  - Equivalent left amount L = (in_dir == 0) ? S : (N - S) mod N.
  - If L <= N - L: steps = L, rotate left. Otherwise: steps = N - L, rotate right.
  - Tie (L == N/2, N even) goes left.
- FSM states IDLE, BUSY, DONE:
  - IDLE: in_ready = 1, out_valid = 0. Accept on in_valid && in_ready at edge E0: latch in_data into the working register, load the step counter and chosen direction. If steps == 0, go to DONE; else go to BUSY.
  - BUSY: in_ready = 0. Each edge rotates the working register by one bit in the chosen direction and decrements the counter. When the counter is 1 on an edge, that edge performs the last rotation and moves to DONE.
  - DONE: out_valid = 1; out_data = working register, stable until the handshake. On out_valid && out_ready, go to IDLE. in_ready = 0 while in DONE, so there is no same-cycle accept; the next request is accepted one cycle after the output handshake.
- Latency: out_valid rises after edge E0 + steps (steps = 0 gives out_valid in the cycle right after E0). Maximum steps = floor(N/2).
- Backpressure: out_ready low holds DONE indefinitely; out_data is unchanged.
- in_valid while not in IDLE is ignored; the upstream must hold the request until in_ready.
- in_amount is not range-checked beyond the mod-N reduction. For non-power-of-two N, values >= N wrap.
- No combinational path from in_valid to out_valid, or from out_ready to in_ready.

Decomposition:
- Package serial_rotator_pkg:
  - enum state_t {IDLE, BUSY, DONE}.
  - enum rot_dir_t {ROT_LEFT = 0, ROT_RIGHT = 1}.
  - Function that computes steps and direction from (amount, dir, N); shared with the testbench reference model.
- Sub-module rotate_by_one_bit (parameter N; inputs data and dir; output rotated data): a purely combinational single-bit rotator, instantiated once in the datapath.

Test Plan:
- N=8, in_data 10110101, amount 3, dir left -> out_data 10101101; out_valid exactly 3 cycles after accept.
- Same data, amount 3, dir right -> out_data 10110110; latency 3 (L = 5, shorter path is right by 3).
- in_data 00000001, amount 6, dir left -> out_data 01000000 with latency 2 (executed as right by 2). Amount 4 left -> 00010000 with latency 4 (tie goes left).
- in_data 11100000, amount 0 -> out_data 11100000; out_valid the cycle after accept; in_ready low until the output handshake.
- Backpressure: out_ready held low for 5 cycles after out_valid -> out_data and out_valid stable; handshake on cycle 6; in_ready high the next cycle; a back-to-back request then completes correctly.
- Reset asserted mid-BUSY (amount 3, after 1 step) -> out_valid = 0, in_ready = 1 and out_data = 0 immediately, without waiting for a clock edge. A fresh request after reset release gives the correct result.
